// File: rtl/cordic_job_arbiter.sv
// rtl/cordic_job_arbiter.sv - round-robin job scheduler sharing one CORDIC controller
// Grants one requester at a time, issues its job, aborts runaway jobs, returns the result to its owner.
module cordic_job_arbiter #(
  parameter int N_REQ   = 4,
  parameter int p_WIDTH = 32,
  parameter int TIMEOUT = 64,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*p_WIDTH-1:0]   req_x,
  input  logic [N_REQ*p_WIDTH-1:0]   req_y,
  input  logic [N_REQ*p_WIDTH-1:0]   req_z,
  input  logic [N_REQ*16-1:0]        req_ctrl,
  output logic [N_REQ-1:0]           rsp_valid,
  input  logic [N_REQ-1:0]           rsp_ready,
  output logic [p_WIDTH-1:0]         rsp_x,
  output logic [p_WIDTH-1:0]         rsp_y,
  output logic [p_WIDTH-1:0]         rsp_z,
  output logic [15:0]                rsp_flags,
  output logic                       rsp_timeout,
  output logic [ID_W-1:0]            rsp_id,
  output logic [31:0]                cordic_ctrl_in,
  output logic [p_WIDTH-1:0]         cordic_x_in,
  output logic [p_WIDTH-1:0]         cordic_y_in,
  output logic [p_WIDTH-1:0]         cordic_z_in,
  input  logic [31:0]                cordic_ctrl_out,
  input  logic [p_WIDTH-1:0]         cordic_x_res,
  input  logic [p_WIDTH-1:0]         cordic_y_res,
  input  logic [p_WIDTH-1:0]         cordic_z_res,
  input  logic                       cordic_wr_en,
  output logic                       busy
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateT;

  stateT              state;
  logic [ID_W-1:0]    rrPtr, curId, winId, candId;
  logic               anyValid;
  logic [p_WIDTH-1:0] xReg, yReg, zReg;
  logic [p_WIDTH-1:0] selX, selY, selZ;
  logic [15:0]        selCtrl;
  logic [10:0]        ctrlBits;
  logic [TW-1:0]      tmoCnt;
  logic               stopSent, done, stopPulse;
  logic [N_REQ-1:0]   rspValidReg;
  logic               unusedBits;

  // First valid requester at or after rrPtr, wrapping around.
  always_comb begin
    anyValid = 1'b0;
    winId    = rrPtr;
    candId   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      candId = ID_W'((int'(rrPtr) + k) % N_REQ);
      if (!anyValid && req_valid[candId]) begin
        anyValid = 1'b1;
        winId    = candId;
      end
    end
  end

  assign selX    = req_x[winId*p_WIDTH +: p_WIDTH];
  assign selY    = req_y[winId*p_WIDTH +: p_WIDTH];
  assign selZ    = req_z[winId*p_WIDTH +: p_WIDTH];
  assign selCtrl = req_ctrl[winId*16 +: 16];

  assign done = cordic_wr_en & cordic_ctrl_out[16];
  // A completion seen on the abort cycle wins: no stop is sent for a job that already finished.
  assign stopPulse = (state == WAIT) && (tmoCnt == TW'(TIMEOUT - 1)) && !stopSent && !done;

  // The accept must land in the same IDLE cycle as the grant decision, so it is not registered.
  assign req_ready = (rst_n && state == IDLE && anyValid) ? (N_REQ'(1) << winId) : '0;

  always_comb begin
    cordic_ctrl_in = 32'h0;
    if (state == ISSUE)  cordic_ctrl_in = {16'b0, 3'b0, ctrlBits, 1'b0, 1'b1};
    else if (stopPulse)  cordic_ctrl_in = 32'h0000_0002;
  end

  assign cordic_x_in = xReg;
  assign cordic_y_in = yReg;
  assign cordic_z_in = zReg;
  assign rsp_valid   = rspValidReg;
  assign rsp_id      = curId;
  assign busy        = (state != IDLE);
  assign unusedBits  = ^{selCtrl[15:13], selCtrl[1:0], cordic_ctrl_out[15:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rrPtr       <= '0;
      curId       <= '0;
      xReg        <= '0;
      yReg        <= '0;
      zReg        <= '0;
      ctrlBits    <= '0;
      tmoCnt      <= '0;
      stopSent    <= 1'b0;
      rspValidReg <= '0;
      rsp_x       <= '0;
      rsp_y       <= '0;
      rsp_z       <= '0;
      rsp_flags   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (anyValid) begin
          xReg     <= selX;
          yReg     <= selY;
          zReg     <= selZ;
          ctrlBits <= selCtrl[12:2];
          curId    <= winId;
          rrPtr    <= ID_W'((int'(winId) + 1) % N_REQ);
          state    <= ISSUE;
        end
        ISSUE: begin
          tmoCnt   <= '0;
          stopSent <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          if (tmoCnt != TW'(TIMEOUT)) tmoCnt <= tmoCnt + 1'b1;
          if (stopPulse) stopSent <= 1'b1;
          if (done) begin
            rsp_x       <= cordic_x_res;
            rsp_y       <= cordic_y_res;
            rsp_z       <= cordic_z_res;
            rsp_flags   <= cordic_ctrl_out[31:16];
            rsp_timeout <= stopSent;
            rspValidReg <= N_REQ'(1) << curId;
            state       <= RESP;
          end
        end
        RESP: if (rsp_ready[curId]) begin
          rspValidReg <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_job_arbiter.sv
// tb/tb_cordic_job_arbiter.sv - directed bench for cordic_job_arbiter with a scripted controller
module tb_cordic_job_arbiter;
  localparam int N_REQ = 4;
  localparam int W = 32;
  localparam int TIMEOUT = 4;
  localparam int ID_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N_REQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N_REQ*W-1:0] req_x, req_y, req_z;
  logic [N_REQ*16-1:0] req_ctrl;
  logic [W-1:0] rsp_x, rsp_y, rsp_z;
  logic [W-1:0] cordic_x_in, cordic_y_in, cordic_z_in;
  logic [W-1:0] cordic_x_res, cordic_y_res, cordic_z_res;
  logic [15:0] rsp_flags;
  logic rsp_timeout, busy, cordic_wr_en;
  logic [ID_W-1:0] rsp_id;
  logic [31:0] cordic_ctrl_in, cordic_ctrl_out;
  int checks = 0;
  int failures = 0;

  cordic_job_arbiter #(.N_REQ(N_REQ), .p_WIDTH(W), .TIMEOUT(TIMEOUT), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_ctrl(req_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
    .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout), .rsp_id(rsp_id),
    .cordic_ctrl_in(cordic_ctrl_in),
    .cordic_x_in(cordic_x_in), .cordic_y_in(cordic_y_in), .cordic_z_in(cordic_z_in),
    .cordic_ctrl_out(cordic_ctrl_out),
    .cordic_x_res(cordic_x_res), .cordic_y_res(cordic_y_res), .cordic_z_res(cordic_z_res),
    .cordic_wr_en(cordic_wr_en), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; rsp_ready = '0;
    req_x = '0; req_y = '0; req_z = '0; req_ctrl = '0;
    cordic_wr_en = 1'b0; cordic_ctrl_out = '0;
    cordic_x_res = '0; cordic_y_res = '0; cordic_z_res = '0;
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
  endtask

  // Controller reports completion with the given flags and results.
  task automatic complete(input logic [15:0] flags, input logic [31:0] xr, yr, zr);
    cordic_wr_en = 1'b1;
    cordic_ctrl_out = {flags, 16'h0000};
    cordic_x_res = xr; cordic_y_res = yr; cordic_z_res = zr;
    #1;
  endtask

  task automatic ctrl_quiet();
    cordic_wr_en = 1'b0;
    cordic_ctrl_out = '0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    checks++; if (cordic_ctrl_in !== 32'h0) begin failures++; $display("FAIL reset_ctrl_in: got %h expected 0", cordic_ctrl_in); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rsp_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b expected 0", rsp_timeout); end
    checks++; if (cordic_x_in !== 32'h0) begin failures++; $display("FAIL reset_x_in: got %h expected 0", cordic_x_in); end
    checks++; if (rsp_flags !== 16'h0) begin failures++; $display("FAIL reset_flags: got %h expected 0", rsp_flags); end
  endtask

  task automatic test_single_rotation();
    do_reset();
    req_x[2*W +: W] = 32'h26DD3B6A;
    req_z[2*W +: W] = 32'h20000000;
    req_ctrl[2*16 +: 16] = 16'h1F0C;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL rot_grant: got %b expected 0100", req_ready); end
    cyc(); req_valid = '0; #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rot_grant_pulse: got %b expected 0000", req_ready); end
    checks++; if (cordic_ctrl_in !== 32'h00001F0D) begin failures++; $display("FAIL rot_start: got %h expected 00001f0d", cordic_ctrl_in); end
    checks++; if (cordic_x_in !== 32'h26DD3B6A) begin failures++; $display("FAIL rot_x_in: got %h expected 26dd3b6a", cordic_x_in); end
    checks++; if (cordic_z_in !== 32'h20000000) begin failures++; $display("FAIL rot_z_in: got %h expected 20000000", cordic_z_in); end
    cyc();
    checks++; if (cordic_ctrl_in !== 32'h0) begin failures++; $display("FAIL rot_start_not_held: got %h expected 0", cordic_ctrl_in); end
    complete(16'h0001, 32'h16A09E60, 32'h16A09E61, 32'h00000003);
    cyc(); ctrl_quiet();
    checks++; if (rsp_valid !== 4'b0100) begin failures++; $display("FAIL rot_rsp_valid: got %b expected 0100", rsp_valid); end
    checks++; if (rsp_id !== 2'd2) begin failures++; $display("FAIL rot_rsp_id: got %0d expected 2", rsp_id); end
    checks++; if (rsp_timeout !== 1'b0) begin failures++; $display("FAIL rot_timeout: got %b expected 0", rsp_timeout); end
    checks++; if (rsp_flags[0] !== 1'b1) begin failures++; $display("FAIL rot_flag0: got %b expected 1", rsp_flags[0]); end
    checks++; if (rsp_y !== 32'h16A09E61) begin failures++; $display("FAIL rot_rsp_y: got %h expected 16a09e61", rsp_y); end
    rsp_ready = 4'b0100;
    cyc(); rsp_ready = '0; #1;
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL rot_rsp_drop: got %b expected 0000", rsp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rot_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] expOh;
    do_reset();
    for (int i = 0; i < N_REQ; i++) req_x[i*W +: W] = 32'h1000 + 32'(i);
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    #1;
    for (int j = 0; j < 8; j++) begin
      expOh = 4'b0001 << (j % 4);
      checks++; if (req_ready !== expOh) begin failures++; $display("FAIL rr_grant%0d: got %b expected %b", j, req_ready, expOh); end
      cyc();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rr_busy_issue%0d: got %b expected 1", j, busy); end
      checks++; if (cordic_x_in !== 32'h1000 + 32'(j % 4)) begin failures++; $display("FAIL rr_x_in%0d: got %h expected %h", j, cordic_x_in, 32'h1000 + 32'(j % 4)); end
      cyc();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rr_busy_wait%0d: got %b expected 1", j, busy); end
      complete(16'h0001, 32'h0, 32'h0, 32'h0);
      cyc(); ctrl_quiet();
      checks++; if (rsp_valid !== expOh) begin failures++; $display("FAIL rr_rsp%0d: got %b expected %b", j, rsp_valid, expOh); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rr_busy_resp%0d: got %b expected 1", j, busy); end
      cyc();
    end
    req_valid = '0;
    rsp_ready = '0;
  endtask

  task automatic test_pointer_wrap();
    do_reset();
    req_ctrl[3*16 +: 16] = 16'hFFFF;
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL wrap_first3: got %b expected 1000", req_ready); end
    cyc(); req_valid = '0; #1;
    checks++; if (cordic_ctrl_in !== 32'h00001FFD) begin failures++; $display("FAIL wrap_ignored_bits: got %h expected 00001ffd", cordic_ctrl_in); end
    cyc(); complete(16'h0001, 32'h0, 32'h0, 32'h0);
    cyc(); ctrl_quiet(); rsp_ready = 4'b1000;
    cyc(); rsp_ready = '0;
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL wrap_grant0: got %b expected 0001", req_ready); end
    cyc(); req_valid = 4'b1000;
    cyc(); complete(16'h0001, 32'h0, 32'h0, 32'h0);
    cyc(); ctrl_quiet(); rsp_ready = 4'b0001;
    cyc(); rsp_ready = '0; #1;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL wrap_grant3: got %b expected 1000", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    logic [31:0] expCtrl;
    int pulses;
    pulses = 0;
    do_reset();
    req_ctrl[0 +: 16] = 16'h1F0C;
    req_valid = 4'b0001;
    #1; cyc(); req_valid = '0;
    cyc();
    for (int i = 1; i <= 6; i++) begin
      expCtrl = (i == 4) ? 32'h2 : 32'h0;
      checks++; if (cordic_ctrl_in !== expCtrl) begin failures++; $display("FAIL tmo_wait%0d: got %h expected %h", i, cordic_ctrl_in, expCtrl); end
      if (cordic_ctrl_in === 32'h2) pulses++;
      cyc();
    end
    complete(16'h0141, 32'h0, 32'h0, 32'h0);
    cyc(); ctrl_quiet();
    checks++; if (pulses !== 1) begin failures++; $display("FAIL tmo_pulse_count: got %0d expected 1", pulses); end
    checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL tmo_rsp_valid: got %b expected 0001", rsp_valid); end
    checks++; if (rsp_timeout !== 1'b1) begin failures++; $display("FAIL tmo_flag: got %b expected 1", rsp_timeout); end
    checks++; if (rsp_flags[10:6] !== 5'd5) begin failures++; $display("FAIL tmo_iters: got %0d expected 5", rsp_flags[10:6]); end
  endtask

  task automatic test_done_no_stop();
    do_reset();
    req_valid = 4'b0001;
    #1; cyc(); req_valid = '0;
    cyc(); cyc(); cyc();
    checks++; if (cordic_ctrl_in !== 32'h0) begin failures++; $display("FAIL edge_wait3: got %h expected 0", cordic_ctrl_in); end
    cyc();
    complete(16'h0001, 32'h0, 32'h0, 32'h0);
    checks++; if (cordic_ctrl_in !== 32'h0) begin failures++; $display("FAIL edge_no_stop: got %h expected 0", cordic_ctrl_in); end
    cyc(); ctrl_quiet();
    checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL edge_rsp_valid: got %b expected 0001", rsp_valid); end
    checks++; if (rsp_timeout !== 1'b0) begin failures++; $display("FAIL edge_timeout: got %b expected 0", rsp_timeout); end
  endtask

  task automatic test_input_error();
    do_reset();
    req_x[1*W +: W] = 32'hF0000000;
    req_ctrl[1*16 +: 16] = 16'h1F04;
    req_valid = 4'b0010;
    #1; cyc(); req_valid = '0; #1;
    checks++; if (cordic_ctrl_in !== 32'h00001F05) begin failures++; $display("FAIL err_start: got %h expected 00001f05", cordic_ctrl_in); end
    checks++; if (cordic_x_in !== 32'hF0000000) begin failures++; $display("FAIL err_x_in: got %h expected f0000000", cordic_x_in); end
    cyc();
    complete(16'h0003, 32'h0, 32'h0, 32'h0);
    checks++; if (cordic_ctrl_in !== 32'h0) begin failures++; $display("FAIL err_no_stop: got %h expected 0", cordic_ctrl_in); end
    cyc(); ctrl_quiet();
    checks++; if (rsp_flags[1] !== 1'b1) begin failures++; $display("FAIL err_flag1: got %b expected 1", rsp_flags[1]); end
    checks++; if (rsp_timeout !== 1'b0) begin failures++; $display("FAIL err_timeout: got %b expected 0", rsp_timeout); end
    checks++; if (rsp_id !== 2'd1) begin failures++; $display("FAIL err_rsp_id: got %0d expected 1", rsp_id); end
  endtask

  task automatic test_backpressure_reset();
    do_reset();
    req_x[0 +: W] = 32'hA5A50001;
    req_valid = 4'b0001;
    #1; cyc(); req_valid = 4'b0010;
    cyc();
    complete(16'h00C1, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F);
    cyc(); ctrl_quiet();
    rsp_ready = 4'b0010;
    #1;
    for (int i = 0; i < 20; i++) begin
      checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL bp_valid%0d: got %b expected 0001", i, rsp_valid); end
      checks++; if (rsp_x !== 32'h12345678) begin failures++; $display("FAIL bp_x%0d: got %h expected 12345678", i, rsp_x); end
      checks++; if (rsp_z !== 32'h0F0F0F0F) begin failures++; $display("FAIL bp_z%0d: got %h expected 0f0f0f0f", i, rsp_z); end
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_no_grant%0d: got %b expected 0000", i, req_ready); end
      cyc();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL arst_req_ready: got %b expected 0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL arst_rsp_valid: got %b expected 0000", rsp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy: got %b expected 0", busy); end
    checks++; if (cordic_ctrl_in !== 32'h0) begin failures++; $display("FAIL arst_ctrl_in: got %h expected 0", cordic_ctrl_in); end
    checks++; if (rsp_x !== 32'h0) begin failures++; $display("FAIL arst_rsp_x: got %h expected 0", rsp_x); end
    checks++; if (rsp_flags !== 16'h0) begin failures++; $display("FAIL arst_flags: got %h expected 0", rsp_flags); end
    checks++; if (cordic_x_in !== 32'h0) begin failures++; $display("FAIL arst_x_in: got %h expected 0", cordic_x_in); end
    checks++; if (rsp_timeout !== 1'b0) begin failures++; $display("FAIL arst_timeout: got %b expected 0", rsp_timeout); end
    cyc();
    rst_n = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
  endtask

  initial begin
    test_reset();
    test_single_rotation();
    test_round_robin();
    test_pointer_wrap();
    test_timeout();
    test_done_no_stop();
    test_input_error();
    test_backpressure_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cordic_job_arbiter.md
# cordic_job_arbiter

Round-robin scheduler that shares one CORDIC controller among `N_REQ` independent requesters. It accepts jobs (x, y, z operands plus control word), issues them one at a time on the controller's bus-side ports (`controlRegisterInput`, `xInput`/`yInput`/`zInput`), and detects completion from the controller's write-enable and ready flag. It returns results and flags to the originating requester and can abort runaway jobs with the controller's stop bit.

## Interface
- `N_REQ`, 4: number of requesters; must be at least 2.
- `p_WIDTH`, 32: operand width.
- `TIMEOUT`, 64: maximum cycles in WAIT before a stop is issued; must be at least 2.
- `ID_W`, $clog2(N_REQ): requester index width.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: per-requester job pending.
- `req_ready` out N_REQ: one-hot, one-cycle accept pulse.
- `req_x`, `req_y`, `req_z` in N_REQ*p_WIDTH: packed operands. Requester i occupies bits [i*32 +: 32].
- `req_ctrl` in N_REQ*16: packed control words. Field layout: [2] mode, [3] system, [4] err int en, [5] result int en, [6] ov stop en, [7] z ov stop en, [12:8] iterations. Bits [1:0] and [15:13] are ignored.
- `rsp_valid` out N_REQ: one-hot; held high until that requester's `rsp_ready` is high.
- `rsp_ready` in N_REQ: response accept.
- `rsp_x`, `rsp_y`, `rsp_z` out p_WIDTH: result of the current response.
- `rsp_flags` out 16: controller flags [31:16] captured at completion.
- `rsp_timeout` out 1: the job was aborted by this block.
- `rsp_id` out ID_W: requester index of the current response.
- `cordic_ctrl_in` out 32: drives the controller's `controlRegisterInput`.
- `cordic_x_in`, `cordic_y_in`, `cordic_z_in` out p_WIDTH: drive the controller's x/y/z inputs.
- `cordic_ctrl_out` in 32: the controller's `controlRegisterOutput`.
- `cordic_x_res`, `cordic_y_res`, `cordic_z_res` in p_WIDTH: the controller's result outputs.
- `cordic_wr_en` in 1: the controller's `controlRegisterWriteEnable`.
- `busy` out 1: high in every state except IDLE.

## Operation
- The state machine has four states: IDLE, ISSUE, WAIT and RESP.
- **IDLE**
  - If any `req_valid` is high, pick the winner: the first valid index at or after `rr_ptr`, wrapping from N_REQ-1 to 0.
  - Pulse `req_ready[winner]`.
  - Latch that requester's operands and control word, and its index into `cur_id`.
  - Set `rr_ptr` to `(winner+1) mod N_REQ` and go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - `cordic_ctrl_in = {16'b0, 3'b0, ctrl[12:2], 1'b0 (stop), 1'b1 (start)}`.
  - Clear `tmo_cnt` and `stop_sent`, then go to WAIT.
- **WAIT**
  - `tmo_cnt` increments each cycle, saturating at TIMEOUT.
  - Done is `cordic_wr_en & cordic_ctrl_out[16]`.
  - On done: capture `cordic_x/y/z_res` into `rsp_x/y/z`, `cordic_ctrl_out[31:16]` into `rsp_flags`, and `stop_sent` into `rsp_timeout`; go to RESP.
  - When `tmo_cnt == TIMEOUT-1` and `stop_sent` is 0, drive `cordic_ctrl_in[1]=1` for exactly one cycle and set `stop_sent`. Remain in WAIT until done.
- **RESP**
  - `rsp_valid[cur_id]=1`; `rsp_id=cur_id`.
  - When `rsp_ready[cur_id]` is high, go to IDLE. `rsp_ready` on other indices is ignored.
- Outside ISSUE and the stop pulse, `cordic_ctrl_in` is all zeros. In particular, start is never held high.
- `cordic_x/y/z_in` are driven continuously from the latched operand registers.
- `req_valid` is level-sensitive. A requester holds its operands stable until its `req_ready` pulse.
- New requests arriving in ISSUE, WAIT or RESP wait; no `req_ready` is given outside IDLE.
- If a requester drops `req_valid` before being granted, nothing is recorded for it.

## Timing
- **Reset values** (`rst_n` low, asynchronous): state IDLE, `rr_ptr=0`, `cur_id=0`.
  - Outputs `req_ready`, `rsp_valid`, `cordic_ctrl_in`, `busy`, `rsp_timeout` are all 0.
  - `rsp_x/y/z` and `rsp_flags` are 0. Operand registers, and therefore `cordic_x/y/z_in`, are 0.
- **Reset mid-job**: the current job is discarded and no response is produced. The controller must be reset in the same cycle by the system.
- **Grant latency**: `req_ready` is asserted in the first IDLE cycle in which `req_valid` is high. Start appears on the following cycle.
- **Completion latency**: the cycle after done is sampled, `rsp_valid` rises. Back-to-back jobs need at least 4 cycles each, plus the controller's runtime.
- **Done with no stop**: if done is sampled in the same cycle that `tmo_cnt` reaches TIMEOUT-1, no stop is sent and `rsp_timeout=0`.
- **Early-exit jobs**: a controller input error (hyperbolic, x<0) completes without a stop. The captured flags show bit 1 (input error, which is bit 17 of the control register).
- **Response held**: `rsp_valid` is held indefinitely while `rsp_ready` is low. No other job starts during this time.

## Test plan
- **Single circular rotation**: reset, then requester 2 sends x=0x26DD3B6A, y=0, z=0x20000000, ctrl=0x1F0C.
  - `req_ready`=4'b0100 for one cycle, then a start pulse.
  - `rsp_valid`=4'b0100 with `rsp_id`=2, `rsp_timeout`=0, and `rsp_flags[0]`=1.
- **Round-robin fairness**: all four `req_valid` held high for 8 jobs, with `rsp_ready` tied high.
  - Grant order is 0,1,2,3,0,1,2,3.
  - `busy` never drops while requests are pending, except the IDLE grant cycle.
- **Pointer wrap**: requesters 3 and 0 request after requester 3 was last served.
  - Requester 0 is granted first, then requester 3.
- **Timeout**: TIMEOUT=4, ctrl iterations=31, hold the controller with no overflow.
  - Exactly one `cordic_ctrl_in`=0x00000002 pulse appears, on the 4th WAIT cycle.
  - The response has `rsp_timeout`=1 and `rsp_flags[10:6]` < 31.
- **Input error**: hyperbolic job (ctrl bit 3=0) with x=0xF0000000.
  - The response has `rsp_flags[1]`=1, `rsp_timeout`=0, and no stop pulse.
- **Backpressure and reset**:
  - Hold `rsp_ready`=0 for 20 cycles: `rsp_valid` and data stay stable and requester 1's pending request is not granted.
  - Then assert `rst_n`=0 mid-RESP: all outputs are 0 immediately, without waiting for a clock edge.
